// File: rtl/vj_scan_pkg.sv
// Shared types and defaults for the pyramid window scanner.
package vj_scan_pkg;

    localparam int unsigned VJ_NUM_LEVELS = 10;
    localparam int unsigned VJ_WIN_SIZE   = 24;
    localparam int unsigned VJ_COORD_W    = 16;
    localparam int unsigned VJ_DATA_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } scan_state_t;

    // Corner index; corner k sits at word (3-k) of the {TL,TR,BL,BR} read bus
    typedef enum logic [1:0] {
        CORNER_TL = 2'd0,
        CORNER_TR = 2'd1,
        CORNER_BL = 2'd2,
        CORNER_BR = 2'd3
    } corner_t;

    // Result record at the default widths
    typedef struct packed {
        logic [3:0]             level;
        logic [VJ_COORD_W-1:0]  row;
        logic [VJ_COORD_W-1:0]  col;
        logic [VJ_DATA_W-1:0]   sum;
        logic [2*VJ_DATA_W-1:0] variance;
    } win_result_t;

endpackage

// File: rtl/scan_result_fifo.sv
// Synchronous result FIFO with occupancy count for the issue credit logic.
// Push and pop together while full is accepted; occupancy is unchanged.
module scan_result_fifo
    import vj_scan_pkg::*;
#(
    parameter type         T     = win_result_t,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  T                         push_data,
    input  logic                     pop,
    output T                         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           do_push, do_pop, full;

    // Pointer and occupancy update
    always_comb begin
        full     = (count_q == (AW+1)'(DEPTH));
        do_pop   = pop && (count_q != '0);
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Control state registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while empty
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/pyramid_window_scanner.sv
// Window scanner over NUM_LEVELS integral images: issues corner reads,
// computes window sum and variance, queues results for the classifier.
// Optional build macro: VAR_REJECT_EN (adds var_thresh low-variance rejection).
module pyramid_window_scanner
    import vj_scan_pkg::*;
#(
    parameter int unsigned NUM_LEVELS = VJ_NUM_LEVELS,
    parameter int unsigned WIN_SIZE   = VJ_WIN_SIZE,
    parameter int unsigned STRIDE     = 1,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned COORD_W    = 16,
    parameter int unsigned BUF_DEPTH  = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [NUM_LEVELS*COORD_W-1:0] level_width,
    input  logic [NUM_LEVELS*COORD_W-1:0] level_height,
    output logic                          rd_en,
    output logic [3:0]                    rd_level,
    output logic [2*COORD_W-1:0]          rd_row,
    output logic [2*COORD_W-1:0]          rd_col,
    input  logic [4*DATA_W-1:0]           rd_data,
    input  logic [4*DATA_W-1:0]           rd_sq_data,
    output logic                          win_valid,
    input  logic                          win_ready,
    output logic [3:0]                    win_level,
    output logic [COORD_W-1:0]            win_row,
    output logic [COORD_W-1:0]            win_col,
    output logic [DATA_W-1:0]             win_sum,
    output logic [2*DATA_W-1:0]           win_var,
`ifdef VAR_REJECT_EN
    input  logic [2*DATA_W-1:0]           var_thresh,
`endif
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned AW = $clog2(BUF_DEPTH);
    localparam logic [COORD_W-1:0]  WIN_CW   = COORD_W'(WIN_SIZE);
    localparam logic [COORD_W-1:0]  STEP_CW  = COORD_W'(STRIDE);
    localparam logic [2*DATA_W-1:0] N_PIX    = (2*DATA_W)'(WIN_SIZE * WIN_SIZE);

    typedef struct packed {
        logic [3:0]          level;
        logic [COORD_W-1:0]  row;
        logic [COORD_W-1:0]  col;
        logic [DATA_W-1:0]   sum;
        logic [2*DATA_W-1:0] variance;
    } result_t;

    function automatic logic [DATA_W-1:0] corner_word(input logic [4*DATA_W-1:0] bus,
                                                      input corner_t k);
        case (k)
            CORNER_TL: corner_word = bus[4*DATA_W-1:3*DATA_W];
            CORNER_TR: corner_word = bus[3*DATA_W-1:2*DATA_W];
            CORNER_BL: corner_word = bus[2*DATA_W-1:DATA_W];
            default:   corner_word = bus[DATA_W-1:0];
        endcase
    endfunction

    scan_state_t        state_q, state_d;
    logic [3:0]         lvl_q, lvl_d;
    logic [COORD_W-1:0] row_q, row_d, col_q, col_d;
    logic               pend_q, pend_d;
    logic [COORD_W-1:0] width_q [NUM_LEVELS];
    logic [COORD_W-1:0] width_d [NUM_LEVELS];
    logic [COORD_W-1:0] height_q [NUM_LEVELS];
    logic [COORD_W-1:0] height_d [NUM_LEVELS];

    logic               s1_v_q, s1_v_d, s2_v_q, s2_v_d;
    logic [3:0]         s1_lvl_q, s1_lvl_d, s2_lvl_q, s2_lvl_d;
    logic [COORD_W-1:0] s1_row_q, s1_row_d, s2_row_q, s2_row_d;
    logic [COORD_W-1:0] s1_col_q, s1_col_d, s2_col_q, s2_col_d;
    logic [DATA_W-1:0]  s2_sum_q, s2_sum_d, s2_sq_q, s2_sq_d;

    logic [COORD_W-1:0] in_w [NUM_LEVELS];
    logic [COORD_W-1:0] in_h [NUM_LEVELS];
    logic [COORD_W-1:0] cur_w, cur_h;
    logic               first_found, nxt_found;
    logic [3:0]         first_lvl, nxt_lvl;
    logic               col_end, row_end, credit_ok, pipe_empty, issue;
    logic [AW+1:0]      occupancy;

    logic [2*DATA_W-1:0] sum_x, sq_x, var_c;
    logic                keep, fifo_push, fifo_pop, fifo_empty;
    logic [AW:0]         fifo_count;
    result_t             push_res, head_res;

    // Level dimensions, level search, end-of-row/level tests and issue credit
    always_comb begin
        first_found = 1'b0;
        first_lvl   = '0;
        nxt_found   = 1'b0;
        nxt_lvl     = '0;
        cur_w       = '0;
        cur_h       = '0;
        for (int unsigned i = 0; i < NUM_LEVELS; i++) begin
            in_w[i] = level_width[i*COORD_W +: COORD_W];
            in_h[i] = level_height[i*COORD_W +: COORD_W];
            if (!first_found && in_w[i] >= WIN_CW && in_h[i] >= WIN_CW) begin
                first_found = 1'b1;
                first_lvl   = 4'(i);
            end
            if (!nxt_found && 4'(i) > lvl_q && width_q[i] >= WIN_CW && height_q[i] >= WIN_CW) begin
                nxt_found = 1'b1;
                nxt_lvl   = 4'(i);
            end
            if (4'(i) == lvl_q) begin
                cur_w = width_q[i];
                cur_h = height_q[i];
            end
        end
        // Widened by one bit so c+STRIDE cannot wrap; w>=W holds for any level being scanned
        col_end    = ({1'b0, col_q} + {1'b0, STEP_CW}) > ({1'b0, cur_w} - {1'b0, WIN_CW});
        row_end    = ({1'b0, row_q} + {1'b0, STEP_CW}) > ({1'b0, cur_h} - {1'b0, WIN_CW});
        occupancy  = (AW+2)'(s1_v_q) + (AW+2)'(s2_v_q) + (AW+2)'(fifo_count);
        credit_ok  = occupancy < (AW+2)'(BUF_DEPTH);
        pipe_empty = !s1_v_q && !s2_v_q && fifo_empty;
    end

    // FSM next state and scan position advance
    always_comb begin
        state_d  = state_q;
        lvl_d    = lvl_q;
        row_d    = row_q;
        col_d    = col_q;
        pend_d   = pend_q;
        width_d  = width_q;
        height_d = height_q;
        issue    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_SCAN;
                    width_d  = in_w;
                    height_d = in_h;
                    lvl_d    = first_lvl;
                    row_d    = '0;
                    col_d    = '0;
                    pend_d   = first_found;
                end
            end
            ST_SCAN: begin
                if (!pend_q) begin
                    state_d = ST_DRAIN;
                end else if (credit_ok) begin
                    issue = 1'b1;
                    if (!col_end) begin
                        col_d = col_q + STEP_CW;
                    end else begin
                        col_d = '0;
                        if (!row_end) begin
                            row_d = row_q + STEP_CW;
                        end else begin
                            row_d = '0;
                            // Skipped levels are jumped over here, so they cost no issue cycles
                            if (nxt_found) begin
                                lvl_d = nxt_lvl;
                            end else begin
                                pend_d  = 1'b0;
                                state_d = ST_DRAIN;
                            end
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Scan control registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            lvl_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            pend_q   <= 1'b0;
            width_q  <= '{default: '0};
            height_q <= '{default: '0};
        end else begin
            state_q  <= state_d;
            lvl_q    <= lvl_d;
            row_q    <= row_d;
            col_q    <= col_d;
            pend_q   <= pend_d;
            width_q  <= width_d;
            height_q <= height_d;
        end
    end

    // Pipeline: corner differences, variance, optional rejection, FIFO push
    always_comb begin
        s1_v_d   = issue;
        s1_lvl_d = lvl_q;
        s1_row_d = row_q;
        s1_col_d = col_q;
        s2_v_d   = s1_v_q;
        s2_lvl_d = s1_lvl_q;
        s2_row_d = s1_row_q;
        s2_col_d = s1_col_q;
        s2_sum_d = corner_word(rd_data, CORNER_BR) - corner_word(rd_data, CORNER_BL)
                 - corner_word(rd_data, CORNER_TR) + corner_word(rd_data, CORNER_TL);
        s2_sq_d  = corner_word(rd_sq_data, CORNER_BR) - corner_word(rd_sq_data, CORNER_BL)
                 - corner_word(rd_sq_data, CORNER_TR) + corner_word(rd_sq_data, CORNER_TL);
        sum_x    = {{DATA_W{1'b0}}, s2_sum_q};
        sq_x     = {{DATA_W{1'b0}}, s2_sq_q};
        var_c    = N_PIX * sq_x - sum_x * sum_x;
`ifdef VAR_REJECT_EN
        keep     = (var_c >= var_thresh);
`else
        keep     = 1'b1;
`endif
        fifo_push         = s2_v_q && keep;
        push_res.level    = s2_lvl_q;
        push_res.row      = s2_row_q;
        push_res.col      = s2_col_q;
        push_res.sum      = s2_sum_q;
        push_res.variance = var_c;
    end

    // Pipeline registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_v_q   <= 1'b0;
            s1_lvl_q <= '0;
            s1_row_q <= '0;
            s1_col_q <= '0;
            s2_v_q   <= 1'b0;
            s2_lvl_q <= '0;
            s2_row_q <= '0;
            s2_col_q <= '0;
            s2_sum_q <= '0;
            s2_sq_q  <= '0;
        end else begin
            s1_v_q   <= s1_v_d;
            s1_lvl_q <= s1_lvl_d;
            s1_row_q <= s1_row_d;
            s1_col_q <= s1_col_d;
            s2_v_q   <= s2_v_d;
            s2_lvl_q <= s2_lvl_d;
            s2_row_q <= s2_row_d;
            s2_col_q <= s2_col_d;
            s2_sum_q <= s2_sum_d;
            s2_sq_q  <= s2_sq_d;
        end
    end

    scan_result_fifo #(
        .T     (result_t),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_res),
        .pop       (fifo_pop),
        .pop_data  (head_res),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Output ports; data is forced to zero whenever it is not valid
    always_comb begin
        rd_en     = issue;
        rd_level  = issue ? lvl_q : '0;
        rd_row    = issue ? {row_q + WIN_CW, row_q} : '0;
        rd_col    = issue ? {col_q + WIN_CW, col_q} : '0;
        win_valid = !fifo_empty;
        fifo_pop  = win_valid && win_ready;
        win_level = win_valid ? head_res.level    : '0;
        win_row   = win_valid ? head_res.row      : '0;
        win_col   = win_valid ? head_res.col      : '0;
        win_sum   = win_valid ? head_res.sum      : '0;
        win_var   = win_valid ? head_res.variance : '0;
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DRAIN) && pipe_empty;
    end

endmodule

// File: doc/pyramid_window_scanner.md
# pyramid_window_scanner

Parametrised successor to the fixed-size pyramid scan FSM. Walks a WIN_SIZE×WIN_SIZE window over NUM_LEVELS integral images of run-time-programmable size, with a configurable stride. For each window it fetches the four corners of the integral and squared-integral images over a read port, computes the window sum and variance, and hands `(level, row, col, sum, var)` to the classifier pipeline over a ready/valid handshake with backpressure.

## Interface
- `NUM_LEVELS`, default 10: pyramid levels scanned, in order 0..NUM_LEVELS-1.
- `WIN_SIZE`, default 24: window edge, in pixels.
- `STRIDE`, default 1: row and column step, in pixels (≥1).
- `DATA_W`, default 32: width of integral-image words.
- `COORD_W`, default 16: width of coordinates and dimensions.
- `BUF_DEPTH`, default 4: output FIFO depth (power of 2, ≥4).

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  pulse: integral images are ready; begin a scan.
- `level_width`  in  NUM_LEVELS×COORD_W  image width per level; sampled on accepted `start`.
- `level_height`  in  NUM_LEVELS×COORD_W  image height per level; sampled on accepted `start`.
- `rd_en`  out  1  corner read request.
- `rd_level`  out  4  level being read.
- `rd_row`, `rd_col`  out  2×COORD_W each  [0]=top/left, [1]=bottom/right, in integral coordinates.
- `rd_data`  in  4×DATA_W  corners {TL,TR,BL,BR}; valid the cycle after `rd_en`.
- `rd_sq_data`  in  4×DATA_W  squared-integral corners, same order and timing.
- `win_valid`  out  1  window result available.
- `win_ready`  in  1  consumer accepts the result.
- `win_level`  out  4  level of the result.
- `win_row`, `win_col`  out  COORD_W each  window top-left.
- `win_sum`  out  DATA_W  window pixel sum.
- `win_var`  out  2·DATA_W  N·sqsum − sum², N = WIN_SIZE².
- `busy`  out  1  high outside IDLE.
- `done`  out  1  one-cycle pulse at scan end.

## Operation
- FSM states are IDLE, SCAN and DRAIN.
- IDLE→SCAN on `start`; the dimensions are latched on that edge. `start` in any other state is ignored.
- SCAN issues one read per cycle when credit allows. Corners are (r,c), (r,c+W), (r+W,c) and (r+W,c+W), with W = WIN_SIZE. Each integral image is (h+1)×(w+1) with a zero row and zero column.
- Scan order within a level is row-major:
  - c steps by STRIDE; the row ends when c+STRIDE > w−W.
  - r steps by STRIDE; the level ends when r+STRIDE > h−W.
- A level with w<W or h<W is skipped and costs zero issue cycles.
- SCAN→DRAIN after the last window of the last level is issued.
- DRAIN→IDLE once the pipeline and FIFO are empty; `done` pulses in that cycle.
- If every level is skipped, SCAN→DRAIN→IDLE and `done` pulses 2 cycles after `start`.
- Arithmetic is modulo 2^DATA_W:
  - sum = BR−BL−TR+TL
  - sqsum = BR−BL−TR+TL, computed on the squared-integral corners
- `win_var` = N·sqsum − sum², unsigned, modulo 2^(2·DATA_W).
- Credit rule: issue only if in-flight + FIFO occupancy < BUF_DEPTH. Results are never dropped.
- Outputs hold stable while `win_valid` && !`win_ready`.

## Timing
- Read issued at cycle t:
  - t+1: sum and sqsum registered.
  - t+2: var registered and pushed to the FIFO.
  - t+3: earliest `win_valid` if the FIFO was empty.
- With `win_ready` held high, throughput is one window per cycle with no bubbles.
- `win_ready` low stalls issue within BUF_DEPTH cycles. In-flight results still land.
- Output values during and after reset:
  - `win_valid`, `rd_en`, `busy` and `done` are 0.
  - All data and coordinate outputs are 0.
  - The FIFO is empty and the FSM is in IDLE.
- Reset mid-scan abandons the scan immediately. No `done` is pulsed.
- Simultaneous FIFO push and pop when full is legal; occupancy stays unchanged.

## Configuration
- `VAR_REJECT_EN`
  - Defined: adds input `var_thresh` (2·DATA_W). Windows with `win_var` < `var_thresh` are discarded before the FIFO push, and their credit is released.
  - Undefined: every window is emitted and the port is absent.

## Structure
- Package `vj_scan_pkg` holds:
  - the `scan_state_t` enum;
  - the `corner_t` typedef (TL/TR/BL/BR index);
  - the `win_result_t` packed struct (level, row, col, sum, var);
  - default WIN_SIZE and NUM_LEVELS constants.
- Sub-module `scan_result_fifo`: synchronous FIFO of `win_result_t`, BUF_DEPTH deep, with count output for the credit logic.

## Test plan
- NUM_LEVELS=1, W=24, 26×25 image, STRIDE=1, all-ones pixels, `win_ready`=1:
  - 6 results: (r,c) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2);
  - sum=576 and var=0 for each;
  - `done` pulses once.
- Level 1 set to 20×20 (<W) among three levels: no results with `win_level`=1; levels 0 and 2 complete.
- `win_ready` held low for 20 cycles mid-scan:
  - `rd_en` drops within BUF_DEPTH cycles;
  - no result is lost or duplicated;
  - sequence resumes in order.
- Constant-pixel image: sum = 576·p; var = 0.
- Checkerboard 0/255 pattern: var = 576·(288·65025) − (288·255)².
- Reset asserted mid-scan, then `start`:
  - outputs are 0 during reset;
  - fresh scan from (0,0,0);
  - a single `done`.
- `VAR_REJECT_EN` with `var_thresh`=1 on a flat image: zero results; `done` still pulses.
